// File: rtl/rv32i_core_if.sv
// Fetch and data memory bus of the rv32i_core. The core is the master; memory
// and memory-mapped devices sit on the slave side.
interface rv32i_core_if;
   // Reads are combinational: RDATA must reflect ARADDR in the same cycle.
   // The write is a one-cycle strobe: the slave captures AWADDR/WDATA on the
   // rising edge while AWVALID is high; there is no ready and no backpressure.
   logic [31:0] IMEM_ARADDR;
   logic [31:0] IMEM_RDATA;
   logic [31:0] DMEM_ARADDR;
   logic [31:0] DMEM_RDATA;
   logic [31:0] DMEM_AWADDR;
   logic [31:0] DMEM_WDATA;
   logic        DMEM_AWVALID;

   modport master (
      output IMEM_ARADDR,
      input  IMEM_RDATA,
      output DMEM_ARADDR,
      input  DMEM_RDATA,
      output DMEM_AWADDR,
      output DMEM_WDATA,
      output DMEM_AWVALID
   );

   modport slave (
      input  IMEM_ARADDR,
      output IMEM_RDATA,
      input  DMEM_ARADDR,
      output DMEM_RDATA,
      input  DMEM_AWADDR,
      input  DMEM_WDATA,
      input  DMEM_AWVALID
   );
endinterface

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back all
// complete in one clock; sub-word stores merge into the read word in-cycle.
module rv32i_core #(
   parameter logic        INTERNAL_MEMORY = 1'b0,
   parameter int          INTMEM_WORDS    = 4096,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input logic          CLK,
   input logic          NRST,
   rv32i_core_if.master bus
);
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6f;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];
   logic [31:0] instr, rdata;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        alt;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v, alu_b, alu_res, mem_addr;
   logic [31:0] load_val, store_data, wb_d, pc_plus4;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        wb_en, is_store, br_taken;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign alt    = instr[30];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // rf_q[0] is reset to zero and never written, so x0 always reads 0.
   assign rs1_v    = rf_q[rs1];
   assign rs2_v    = rf_q[rs2];
   assign pc_plus4 = pc_q + 32'd4;
   assign mem_addr = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);

   always_comb begin
      alu_b   = (opcode == OPC_OP) ? rs2_v : imm_i;
      alu_res = '0;
      case (funct3)
         3'b000: alu_res = (opcode == OPC_OP && alt) ? rs1_v - alu_b : rs1_v + alu_b;
         3'b001: alu_res = rs1_v << alu_b[4:0];
         3'b010: alu_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
         3'b011: alu_res = {31'd0, rs1_v < alu_b};
         3'b100: alu_res = rs1_v ^ alu_b;
         3'b101: alu_res = alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
         3'b110: alu_res = rs1_v | alu_b;
         default: alu_res = rs1_v & alu_b;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  br_taken = (rs1_v == rs2_v);
         3'b001:  br_taken = (rs1_v != rs2_v);
         3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
         3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110:  br_taken = (rs1_v < rs2_v);
         3'b111:  br_taken = (rs1_v >= rs2_v);
         default: br_taken = 1'b0;
      endcase
   end

   assign ld_byte = rdata[{mem_addr[1:0], 3'b000} +: 8];
   assign ld_half = mem_addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      case (funct3)
         3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_val = {24'd0, ld_byte};
         3'b101:  load_val = {16'd0, ld_half};
         default: load_val = rdata;
      endcase
   end

   // Sub-word stores rewrite only the addressed lane of the word being read.
   always_comb begin
      store_data = rdata;
      case (funct3[1:0])
         2'b00: store_data[{mem_addr[1:0], 3'b000} +: 8] = rs2_v[7:0];
         2'b01: begin
            if (mem_addr[1]) store_data[31:16] = rs2_v[15:0];
            else             store_data[15:0]  = rs2_v[15:0];
         end
         default: store_data = rs2_v;
      endcase
   end

   always_comb begin
      pc_d     = pc_plus4;
      wb_d     = '0;
      wb_en    = 1'b0;
      is_store = 1'b0;
      case (opcode)
         OPC_LUI:    begin wb_en = 1'b1; wb_d = imm_u;          end
         OPC_AUIPC:  begin wb_en = 1'b1; wb_d = pc_q + imm_u;   end
         OPC_JAL:    begin wb_en = 1'b1; wb_d = pc_plus4; pc_d = pc_q + imm_j; end
         OPC_JALR:   begin
            wb_en = 1'b1;
            wb_d  = pc_plus4;
            pc_d  = (rs1_v + imm_i) & ~32'd1;
         end
         OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
         OPC_LOAD:   begin wb_en = 1'b1; wb_d = load_val; end
         OPC_STORE:  is_store = 1'b1;
         OPC_OPIMM,
         OPC_OP:     begin wb_en = 1'b1; wb_d = alu_res; end
         default:    ;
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         pc_q <= pc_d;
         if (wb_en && rd != 5'd0) rf_q[rd] <= wb_d;
      end
   end

   assign bus.IMEM_ARADDR = pc_q;
   assign bus.DMEM_ARADDR = mem_addr;
   assign bus.DMEM_AWADDR = mem_addr;
   assign bus.DMEM_WDATA  = store_data;

   generate
      if (INTERNAL_MEMORY) begin : g_intmem
         localparam int AW = $clog2(INTMEM_WORDS);
         logic [31:0] mem_q [INTMEM_WORDS];

         always_ff @(posedge CLK) begin
            if (NRST && is_store) mem_q[mem_addr[AW+1:2]] <= store_data;
         end

         assign instr            = mem_q[pc_q[AW+1:2]];
         assign rdata            = mem_q[mem_addr[AW+1:2]];
         assign bus.DMEM_AWVALID = 1'b0;
      end else begin : g_extmem
         assign instr            = bus.IMEM_RDATA;
         assign rdata            = bus.DMEM_RDATA;
         assign bus.DMEM_AWVALID = NRST & is_store;
      end
   endgenerate
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: a program table with per-instruction expected
// PC and bus activity, followed by an asynchronous reset sequence.
module tb_rv32i_core;
   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, LOAD = 7'h03, OPIMM = 7'h13;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  kind;   // 0: no access checked, 1: store, 2: load address
      logic [31:0] addr;
      logic [31:0] wdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] imem [256];
   logic [31:0] dmem [1024];
   vec_t        tv [$];
   vec_t        rv [$];
   int          total = 0;
   int          bad = 0;

   rv32i_core_if bus_if ();

   rv32i_core #(
      .INTERNAL_MEMORY(1'b0),
      .INTMEM_WORDS   (4096),
      .RESET_PC       (32'h0000_0000)
   ) dut (
      .CLK (clk),
      .NRST(nrst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   assign bus_if.IMEM_RDATA = imem[bus_if.IMEM_ARADDR[9:2]];
   assign bus_if.DMEM_RDATA = dmem[bus_if.DMEM_ARADDR[11:2]];

   always @(posedge clk) begin
      if (bus_if.DMEM_AWVALID) dmem[bus_if.DMEM_AWADDR[11:2]] <= bus_if.DMEM_WDATA;
   end

   function automatic logic [31:0] i_t(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                       logic [4:0] rd, logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] s_t(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                       logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] b_t(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                       logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] u_t(logic [31:0] imm20, logic [4:0] rd, logic [6:0] op);
      return {imm20[19:0], rd, op};
   endfunction

   function automatic logic [31:0] j_t(logic [31:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                       logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   task automatic add(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] kind,
                      input logic [31:0] addr, input logic [31:0] wdata);
      tv.push_back('{pc, instr, kind, addr, wdata});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_row(input string tag, input int i, input vec_t v);
      check($sformatf("%s%0d_pc", tag, i), bus_if.IMEM_ARADDR, v.pc);
      check($sformatf("%s%0d_awvalid", tag, i), {31'd0, bus_if.DMEM_AWVALID}, {31'd0, v.kind == 2'd1});
      if (v.kind == 2'd1) begin
         check($sformatf("%s%0d_awaddr", tag, i), bus_if.DMEM_AWADDR, v.addr);
         check($sformatf("%s%0d_wdata", tag, i), bus_if.DMEM_WDATA, v.wdata);
      end else if (v.kind == 2'd2) begin
         check($sformatf("%s%0d_araddr", tag, i), bus_if.DMEM_ARADDR, v.addr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      add(32'h00, i_t(5, 0, 3'b000, 1, OPIMM), 0, 0, 0);
      add(32'h04, i_t(32'hFFFF_FFF9, 1, 3'b000, 2, OPIMM), 0, 0, 0);
      add(32'h08, s_t(0, 1, 0, 3'b010), 1, 32'h0, 32'h5);
      add(32'h0C, s_t(4, 2, 0, 3'b010), 1, 32'h4, 32'hFFFF_FFFE);
      add(32'h10, i_t(32'h100, 0, 3'b000, 1, OPIMM), 0, 0, 0);
      add(32'h14, i_t(32'h55, 0, 3'b000, 2, OPIMM), 0, 0, 0);
      add(32'h18, s_t(1, 2, 1, 3'b000), 1, 32'h101, 32'hDEAD_55EF);
      add(32'h1C, s_t(2, 2, 1, 3'b001), 1, 32'h102, 32'h0055_55EF);
      add(32'h20, j_t(16, 1), 0, 0, 0);
      add(32'h30, s_t(8, 1, 0, 3'b010), 1, 32'h8, 32'h24);
      add(32'h34, i_t(32'h200, 0, 3'b000, 4, OPIMM), 0, 0, 0);
      add(32'h38, i_t(0, 4, 3'b000, 5, LOAD), 2, 32'h200, 0);
      add(32'h3C, i_t(3, 4, 3'b100, 6, LOAD), 2, 32'h203, 0);
      add(32'h40, i_t(2, 4, 3'b001, 7, LOAD), 2, 32'h202, 0);
      add(32'h44, i_t(0, 4, 3'b101, 8, LOAD), 2, 32'h200, 0);
      add(32'h48, i_t(0, 4, 3'b010, 9, LOAD), 2, 32'h200, 0);
      add(32'h4C, s_t(32'h10, 5, 0, 3'b010), 1, 32'h10, 32'hFFFF_FFF3);
      add(32'h50, s_t(32'h14, 6, 0, 3'b010), 1, 32'h14, 32'h0000_0080);
      add(32'h54, s_t(32'h18, 7, 0, 3'b010), 1, 32'h18, 32'hFFFF_8081);
      add(32'h58, s_t(32'h1C, 8, 0, 3'b010), 1, 32'h1C, 32'h0000_82F3);
      add(32'h5C, s_t(32'h20, 9, 0, 3'b010), 1, 32'h20, 32'h8081_82F3);
      add(32'h60, i_t(32'hFFFF_FFFF, 0, 3'b000, 10, OPIMM), 0, 0, 0);
      add(32'h64, i_t(1, 0, 3'b000, 11, OPIMM), 0, 0, 0);
      add(32'h68, b_t(8, 11, 10, 3'b100), 0, 0, 0);
      add(32'h70, b_t(16, 11, 10, 3'b110), 0, 0, 0);
      add(32'h74, i_t(32'hE0, 0, 3'b000, 5, OPIMM), 0, 0, 0);
      add(32'h78, i_t(32'h80, 0, 3'b000, 13, OPIMM), 0, 0, 0);
      add(32'h7C, i_t(3, 5, 3'b000, 0, JALR), 0, 0, 0);
      add(32'hE2, i_t(0, 13, 3'b000, 0, JALR), 0, 0, 0);
      add(32'h80, u_t(32'hF0000, 14, LUI), 0, 0, 0);
      add(32'h84, u_t(32'hCAFED, 15, LUI), 0, 0, 0);
      add(32'h88, i_t(32'hFFFF_FAFE, 15, 3'b000, 15, OPIMM), 0, 0, 0);
      add(32'h8C, s_t(0, 15, 14, 3'b010), 1, 32'hF000_0000, 32'hCAFE_CAFE);
      add(32'h90, i_t(7, 0, 3'b000, 0, OPIMM), 0, 0, 0);
      add(32'h94, s_t(32'h24, 0, 0, 3'b010), 1, 32'h24, 32'h0);
      add(32'h98, r_t(7'h20, 10, 11, 3'b000, 16), 0, 0, 0);
      add(32'h9C, i_t(32'h404, 14, 3'b101, 17, OPIMM), 0, 0, 0);
      add(32'hA0, r_t(7'h00, 11, 10, 3'b010, 18), 0, 0, 0);
      add(32'hA4, r_t(7'h00, 11, 10, 3'b011, 19), 0, 0, 0);
      add(32'hA8, s_t(32'h28, 16, 0, 3'b010), 1, 32'h28, 32'h2);
      add(32'hAC, s_t(32'h2C, 17, 0, 3'b010), 1, 32'h2C, 32'hFF00_0000);
      add(32'hB0, s_t(32'h30, 18, 0, 3'b010), 1, 32'h30, 32'h1);
      add(32'hB4, s_t(32'h34, 19, 0, 3'b010), 1, 32'h34, 32'h0);
      add(32'hB8, u_t(32'h1, 20, AUIPC), 0, 0, 0);
      add(32'hBC, s_t(32'h38, 20, 0, 3'b010), 1, 32'h38, 32'h0000_10B8);
      add(32'hC0, s_t(32'h3C, 1, 0, 3'b010), 1, 32'h3C, 32'h0000_0024);

      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
      foreach (tv[i]) imem[tv[i].pc[9:2]] = tv[i].instr;
      dmem[32'h100 >> 2] = 32'hDEAD_BEEF;
      dmem[32'h200 >> 2] = 32'h8081_82F3;

      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", bus_if.IMEM_ARADDR, 32'h0);
      check("reset_awvalid", {31'd0, bus_if.DMEM_AWVALID}, 32'h0);

      @(negedge clk);
      nrst = 1'b1;
      foreach (tv[i]) begin
         #1;
         check_row("prog", i, tv[i]);
         if (i != tv.size() - 1) @(negedge clk);
      end

      // Store at 0xC0 is on the bus; reset lands before its edge.
      #2;
      nrst = 1'b0;
      #1;
      check("async_pc", bus_if.IMEM_ARADDR, 32'h0);
      check("async_awvalid", {31'd0, bus_if.DMEM_AWVALID}, 32'h0);
      @(posedge clk);
      #1;
      check("aborted_store", dmem[32'h3C >> 2], 32'h0);

      rv.push_back('{32'h00, s_t(32'h40, 1, 0, 3'b010), 2'd1, 32'h40, 32'h0});
      rv.push_back('{32'h04, s_t(32'h44, 20, 0, 3'b010), 2'd1, 32'h44, 32'h0});
      rv.push_back('{32'h08, i_t(9, 0, 3'b000, 0, OPIMM), 2'd0, 32'h0, 32'h0});
      rv.push_back('{32'h0C, s_t(32'h48, 0, 0, 3'b010), 2'd1, 32'h48, 32'h0});
      foreach (rv[i]) imem[rv[i].pc[9:2]] = rv[i].instr;

      @(negedge clk);
      nrst = 1'b1;
      foreach (rv[i]) begin
         #1;
         check_row("rst", i, rv[i]);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I integer core; executes one instruction per CLK.
- Instruction fetch uses a combinational, word-addressed read port.
- Data memory has a combinational read port and a full-word write port; there are no byte strobes.
- Sub-word stores are done inside the core as read-modify-write within the same cycle.
- Sits under the system top; memory and memory-mapped test devices are external.

Parameters:
- INTERNAL_MEMORY, 1'b0: 0 = use the external IMEM/DMEM ports. 1 = use an internal unified word array of INTMEM_WORDS; external write is then held off (DMEM_AWVALID=0) and read inputs are ignored.
- INTMEM_WORDS, 4096: depth of the internal array, in 32-bit words.
- RESET_PC, 32'h0000_0000: PC value loaded by reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- NRST  in  1  asynchronous active-low reset.
- IMEM_ARADDR  out  32  byte address of the fetch; equals PC.
- IMEM_RDATA  in  32  instruction word at IMEM_ARADDR, valid in the same cycle.
- DMEM_ARADDR  out  32  load/store effective address, rs1+imm. Lower 2 bits are not cleared.
- DMEM_RDATA  in  32  word containing DMEM_ARADDR, valid in the same cycle.
- DMEM_AWADDR  out  32  store address; equal to DMEM_ARADDR.
- DMEM_WDATA  out  32  full merged word to write.
- DMEM_AWVALID  out  1  write strobe; memory captures AWADDR/WDATA on the rising edge while it is high.

Behaviour:
- Reset (NRST=0, asynchronous):
  - PC=RESET_PC.
  - x1..x31 = 0.
  - DMEM_AWVALID forced 0.
  - IMEM_ARADDR=RESET_PC.
  - Execution starts on the first rising edge after NRST rises.
- x0 reads 0; writes to x0 are discarded.
- Every cycle:
  - decode IMEM_RDATA;
  - read rs1/rs2 combinationally;
  - compute ALU result, branch/jump target and memory address;
  - on the edge, write back rd and update PC.
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
- FENCE, ECALL, EBREAK, SYSTEM/CSR and any unknown opcode execute as NOP (PC+4, no writes).
- Arithmetic and control-flow rules:
  - All arithmetic is modulo 2^32.
  - Shift amount is the low 5 bits of the operand.
  - SLT compares signed; SLTU compares unsigned.
  - JALR target is (rs1+imm) with bit 0 cleared; rd gets PC+4.
  - JAL/JALR with rd=x0 perform no write.
  - Branch taken: PC+imm_B. Not taken: PC+4.
  - Misaligned targets are not trapped; bits are used as computed.
- Loads (lane selected by DMEM_ARADDR[1:0]):
  - LB/LBU take byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU take half lane addr[1] (addr[0] ignored), sign- or zero-extended.
  - LW returns DMEM_RDATA unchanged.
- Stores (DMEM_AWVALID=1 only in the store cycle):
  - SW: WDATA=rs2.
  - SB: WDATA=DMEM_RDATA with byte lane addr[1:0] replaced by rs2[7:0].
  - SH: WDATA=DMEM_RDATA with half lane addr[1] replaced by rs2[15:0].
- DMEM_AWVALID is 0 for every non-store instruction.
- DMEM_ARADDR/AWADDR are driven with the computed address every cycle; the value is don't-care when not loading or storing.
- No stalls, no exceptions, no interrupts.
- Store-then-load to the same address in consecutive cycles sees the new data, because the external write lands on the edge.
- Reset asserted mid-instruction aborts it; no register or memory write occurs.

Test Plan:
- Reset, then ADDI x1,x0,5; ADDI x2,x1,-7 -> x1=5, x2=0xFFFF_FFFE; IMEM_ARADDR steps 0,4,8.
- Byte-write merge:
  - Memory word at 0x100 = 0xDEADBEEF; x1=0x100, x2=0x55.
  - SB x2,1(x1) -> single cycle with AWVALID=1, AWADDR=0x101, WDATA=0xDEAD55EF.
  - Then SH x2,2(x1) -> WDATA=0x005555EF.
- Loads with word 0x8081_82F3 at 0x200:
  - LB off 0 -> 0xFFFF_FFF3.
  - LBU off 3 -> 0x80.
  - LH off 2 -> 0xFFFF_8081.
  - LHU off 0 -> 0x82F3.
  - LW -> 0x8081_82F3.
- Branch/jump:
  - BLT x(-1),x(1) taken; BLTU with the same operands not taken.
  - JAL x1,+16 at PC 0x20 -> x1=0x24, PC=0x30.
  - JALR x0,3(x5) with x5=0x40 -> PC=0x42.
- MMIO store: LUI/ADDI build 0xF0000000 and 0xCAFECAFE; SW -> AWVALID=1, AWADDR=0xF0000000, WDATA=0xCAFECAFE for exactly one cycle.
- Async reset mid-run: pull NRST low between edges -> PC/IMEM_ARADDR=RESET_PC and AWVALID=0 immediately; registers read 0 after release; writes to x0 leave x0=0.
